// File: rtl/fifo_stream_pkg.sv
// Shared types and width helpers for the show-ahead FIFO stream drain.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BURST = 2'd1,
        DRAIN      = 2'd2
    } drain_state_t;

    // Framing flags carried alongside each buffered word.
    typedef struct packed {
        logic sop;
        logic eop;
    } frame_flags_t;

    localparam int SKID_DEPTH = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered skid buffer between a push port and a valid/ready output.
// Latency: a pushed word is presented at the output on the next cycle.
// Backpressure: o_push_rdy drops only when both entries are full and the output is stalled.
module stream_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_push_rdy,
    output logic             o_pop_vld,
    output logic [WIDTH-1:0] o_pop_dat,
    input  logic             i_pop_rdy
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_push;
    logic             w_pop;

    assign o_pop_vld  = (r_occ != 2'd0);
    assign o_pop_dat  = r_head;
    // A full buffer still accepts a word when the head leaves this same cycle.
    assign o_push_rdy = (r_occ != 2'd2) || i_pop_rdy;
    assign w_pop      = o_pop_vld && i_pop_rdy;
    assign w_push     = i_push_vld && o_push_rdy;

    // Head always holds the oldest word; tail is only used when two are held.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (w_push) begin
                        r_head <= i_push_dat;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= i_push_dat;
                    end else if (w_push) begin
                        r_tail <= i_push_dat;
                        r_occ  <= 2'd2;
                    end else if (w_pop) begin
                        r_occ  <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) begin
                            r_tail <= i_push_dat;
                        end else begin
                            r_occ  <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a show-ahead FIFO in bursts and emits the words as a framed valid/ready stream.
// Latency: word popped with rdreq in cycle N is valid on src_* in cycle N+1.
// Backpressure: src_ready_i low fills the 2-entry skid buffer, after which rdreq is withheld.
module fifo_stream_drain
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH          = 32,
    parameter int AWIDTH          = 4,
    parameter int PKT_LEN         = 8,
    parameter int BURST_THRESHOLD = 4,
    parameter int TIMEOUT         = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    input  logic [AWIDTH:0]   fifo_usedw_i,
    output logic              fifo_rdreq_o,
    input  logic              flush_i,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              idle_o
);

    localparam int                WORD_W    = cnt_width(PKT_LEN);
    localparam int                TMO_W     = cnt_width(TIMEOUT);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(PKT_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [AWIDTH:0]   USEDW_THR = (AWIDTH + 1)'(BURST_THRESHOLD);
    localparam logic [AWIDTH:0]   USEDW_ONE = (AWIDTH + 1)'(1);

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        frame_flags_t      flags;
    } skid_entry_t;

    localparam int ENTRY_W = $bits(skid_entry_t);

    drain_state_t      r_state;
    drain_state_t      w_state_nxt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [WORD_W-1:0] r_word_cnt;
    logic              w_room;
    logic              w_rdreq;
    logic              w_burst_ready;
    logic              w_tmo_hit;
    logic              w_src_vld;
    skid_entry_t       w_push_entry;
    skid_entry_t       w_head_entry;

    assign w_burst_ready = (fifo_usedw_i >= USEDW_THR);
    assign w_tmo_hit     = (r_tmo_cnt == TMO_LAST);
    // Pop only while draining, never from an empty FIFO, and only with skid room.
    assign w_rdreq       = (r_state == DRAIN) && !fifo_empty_i && w_room;
    assign fifo_rdreq_o  = w_rdreq;

    // Frame flags are decided at push time so they travel with the word.
    assign w_push_entry.data      = fifo_q_i;
    assign w_push_entry.flags.sop = (r_word_cnt == '0);
    assign w_push_entry.flags.eop = (r_word_cnt == WORD_LAST);

    // Next-state decision: burst start, partial-drain timeout, and drain completion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!fifo_empty_i) begin
                    w_state_nxt = (w_burst_ready || flush_i) ? DRAIN : WAIT_BURST;
                end
            end
            WAIT_BURST: begin
                if (w_burst_ready || flush_i || w_tmo_hit) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty_i || (w_rdreq && (fifo_usedw_i == USEDW_ONE))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeout counter runs only while staying in WAIT_BURST and clears on exit.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == WAIT_BURST) && (w_state_nxt == WAIT_BURST)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Word position within the packet; survives across bursts and timeouts.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_word_cnt <= '0;
        end else if (w_rdreq) begin
            r_word_cnt <= (r_word_cnt == WORD_LAST) ? '0 : r_word_cnt + 1'b1;
        end
    end

    stream_skid_buf #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .i_clk      (clk_i),
        .i_arst_n   (arst_n_i),
        .i_push_vld (w_rdreq),
        .i_push_dat (w_push_entry),
        .o_push_rdy (w_room),
        .o_pop_vld  (w_src_vld),
        .o_pop_dat  (w_head_entry),
        .i_pop_rdy  (src_ready_i)
    );

    assign src_valid_o         = w_src_vld;
    assign src_data_o          = w_head_entry.data;
    assign src_startofpacket_o = w_src_vld && w_head_entry.flags.sop;
    assign src_endofpacket_o   = w_src_vld && w_head_entry.flags.eop;
    assign idle_o              = (r_state == IDLE) && !w_src_vld;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench: FIFO model in front, handshake recorder behind, checks inline.
// Latency: n/a.
// Backpressure: src_ready pattern driven per step.
module tb_fifo_stream_drain;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          arst_n = 1'b1;
    logic [DW-1:0] fifo_q;
    logic          fifo_empty;
    logic [AW:0]   fifo_usedw;
    logic          fifo_rdreq;
    logic          flush = 1'b0;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ready = 1'b1;
    logic          sop;
    logic          eop;
    logic          idle;

    always #5 clk = ~clk;

    fifo_stream_drain dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .fifo_q_i            (fifo_q),
        .fifo_empty_i        (fifo_empty),
        .fifo_usedw_i        (fifo_usedw),
        .fifo_rdreq_o        (fifo_rdreq),
        .flush_i             (flush),
        .src_data_o          (src_data),
        .src_valid_o         (src_valid),
        .src_ready_i         (src_ready),
        .src_startofpacket_o (sop),
        .src_endofpacket_o   (eop),
        .idle_o              (idle)
    );

    // Show-ahead FIFO model: writes from the stimulus, pops on rdreq.
    logic [DW-1:0] fmem [0:255];
    logic [7:0]    wp = 8'd0;
    logic [7:0]    rp = 8'd0;
    logic [7:0]    fill;

    assign fill       = wp - rp;
    assign fifo_q     = fmem[rp];
    assign fifo_empty = (wp == rp);
    assign fifo_usedw = fill[AW:0];

    always @(posedge clk) begin
        if (fifo_rdreq && (wp != rp)) rp <= rp + 8'd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake recorder plus protocol watchers.
    logic [DW-1:0] out_dat [$];
    logic          out_sop [$];
    logic          out_eop [$];
    int            out_cyc [$];
    int            rd_cyc  [$];
    int            occ_m = 0;
    int            viol = 0;
    logic          stall_prev = 1'b0;
    logic [DW+1:0] stall_snap;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occ_m      = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (!src_valid || ({src_data, sop, eop} != stall_snap))) viol++;
            if (fifo_rdreq && (occ_m == 2) && !(src_valid && src_ready)) viol++;
            if (fifo_rdreq && fifo_empty) viol++;
            if (fifo_rdreq) begin
                rd_cyc.push_back(cyc);
                occ_m++;
            end
            if (src_valid && src_ready) begin
                out_dat.push_back(src_data);
                out_sop.push_back(sop);
                out_eop.push_back(eop);
                out_cyc.push_back(cyc);
                occ_m--;
            end
            if (occ_m > 2 || occ_m < 0) viol++;
            stall_prev = src_valid && !src_ready;
            stall_snap = {src_data, sop, eop};
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wp] = base + DW'(i);
            wp       = wp + 8'd1;
        end
    endtask

    task automatic clear_logs();
        out_dat.delete();
        out_sop.delete();
        out_eop.delete();
        out_cyc.delete();
        rd_cyc.delete();
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (out_dat.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, out_dat.size(), n);
    endtask

    int t0;

    initial begin
        // Reset values, asserted between edges.
        #1 arst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, src_valid}, 32'd0);
        chk("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
        chk("rst_sop", {31'd0, sop}, 32'd0);
        chk("rst_eop", {31'd0, eop}, 32'd0);
        chk("rst_data", src_data, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // Threshold drain: 4 words, no WAIT_BURST, packet words 0..3.
        clear_logs();
        push_words(32'hA0, 4);
        t0 = cyc;
        wait_out("thr_count", 4, 40);
        chk("thr_rd_n", rd_cyc.size(), 32'd4);
        chk("thr_rd_first", rd_cyc[0] - t0, 32'd1);
        chk("thr_rd_last", rd_cyc[3] - t0, 32'd4);
        chk("thr_out_first", out_cyc[0] - t0, 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk("thr_data", out_dat[i], 32'hA0 + i);
            chk("thr_sop", {31'd0, out_sop[i]}, (i == 0) ? 32'd1 : 32'd0);
            chk("thr_eop", {31'd0, out_eop[i]}, 32'd0);
        end
        chk("thr_idle", {31'd0, idle}, 32'd1);

        // Timeout: 2 words below threshold, words 4..5 of the packet.
        @(negedge clk);
        clear_logs();
        push_words(32'hB0, 2);
        t0 = cyc;
        @(negedge clk);
        chk("tmo_wait_idle", {31'd0, idle}, 32'd0);
        chk("tmo_wait_rd", {31'd0, fifo_rdreq}, 32'd0);
        wait_out("tmo_count", 2, 60);
        chk("tmo_rd_first", rd_cyc[0] - t0, 32'd17);
        for (int i = 0; i < 2; i++) begin
            chk("tmo_data", out_dat[i], 32'hB0 + i);
            chk("tmo_flags", {30'd0, out_sop[i], out_eop[i]}, 32'd0);
        end

        // Flush in WAIT_BURST: word 6 of the packet.
        @(negedge clk);
        clear_logs();
        push_words(32'hC0, 1);
        t0 = cyc;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_out("fl_count", 1, 20);
        chk("fl_rd_first", rd_cyc[0] - t0, 32'd2);
        chk("fl_data", out_dat[0], 32'hC0);
        chk("fl_flags", {30'd0, out_sop[0], out_eop[0]}, 32'd0);

        // Flush with an empty FIFO is ignored.
        @(negedge clk);
        clear_logs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_empty_idle", {31'd0, idle}, 32'd1);
        repeat (3) @(negedge clk);
        chk("fl_empty_rd", rd_cyc.size(), 32'd0);

        // Word 7 closes the packet spread over four bursts.
        clear_logs();
        push_words(32'hE0, 1);
        wait_out("wrap_count", 1, 40);
        chk("wrap_eop", {31'd0, out_eop[0]}, 32'd1);
        chk("wrap_sop", {31'd0, out_sop[0]}, 32'd0);

        // Packet spanning a threshold burst of 5 and a timeout burst of 3.
        @(negedge clk);
        clear_logs();
        push_words(32'hF0, 5);
        wait_out("span_a", 5, 40);
        @(negedge clk);
        push_words(32'hF5, 3);
        wait_out("span_b", 8, 60);
        for (int i = 0; i < 8; i++) begin
            chk("span_data", out_dat[i], 32'hF0 + i);
            chk("span_sop", {31'd0, out_sop[i]}, (i == 0) ? 32'd1 : 32'd0);
            chk("span_eop", {31'd0, out_eop[i]}, (i == 7) ? 32'd1 : 32'd0);
        end

        // Backpressure with ready 1,0,0,1; next packet starts with SOP.
        @(negedge clk);
        clear_logs();
        viol = 0;
        push_words(32'hD0, 8);
        for (int k = 0; k < 200 && out_dat.size() < 8; k++) begin
            src_ready = ((k % 4) == 0) || ((k % 4) == 3);
            @(negedge clk);
        end
        src_ready = 1'b1;
        chk("bp_count", out_dat.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("bp_data", out_dat[i], 32'hD0 + i);
            chk("bp_sop", {31'd0, out_sop[i]}, (i == 0) ? 32'd1 : 32'd0);
            chk("bp_eop", {31'd0, out_eop[i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        chk("bp_protocol", viol, 32'd0);

        // Async reset with the skid buffer full and a pop pending.
        repeat (2) @(negedge clk);
        clear_logs();
        src_ready = 1'b0;
        push_words(32'h90, 4);
        repeat (4) @(negedge clk);
        chk("ar_pre_valid", {31'd0, src_valid}, 32'd1);
        chk("ar_pre_rd", {31'd0, fifo_rdreq}, 32'd0);
        src_ready = 1'b1;
        #1;
        chk("ar_pre_rd_pop", {31'd0, fifo_rdreq}, 32'd1);
        #1 arst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, src_valid}, 32'd0);
        chk("ar_rdreq", {31'd0, fifo_rdreq}, 32'd0);
        chk("ar_idle", {31'd0, idle}, 32'd1);
        @(negedge clk);
        clear_logs();
        arst_n = 1'b1;
        wait_out("ar_count", 2, 60);
        chk("ar_data0", out_dat[0], 32'h92);
        chk("ar_sop0", {31'd0, out_sop[0]}, 32'd1);
        chk("ar_data1", out_dat[1], 32'h93);
        chk("ar_sop1", {31'd0, out_sop[1]}, 32'd0);
        repeat (3) @(negedge clk);
        chk("ar_no_extra", out_dat.size(), 32'd2);
        chk("ar_end_idle", {31'd0, idle}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Downstream consumer of the show-ahead fifo. Pops words from the FIFO read port and presents them as a valid/ready streaming source with start/end-of-packet framing.
- Drains in bursts: waits until the FIFO holds BURST_THRESHOLD words, or a timeout or flush occurs, then streams until the FIFO is empty.
- A 2-entry skid buffer decouples the FIFO read timing from downstream backpressure.

Parameters:
- DWIDTH, 32, data word width; matches the fifo DWIDTH.
- AWIDTH, 4, fifo address width; the usedw input is AWIDTH+1 bits.
- PKT_LEN, 8, words per packet; valid range 1..2**16.
- BURST_THRESHOLD, 4, usedw level that starts a drain; range 1..2**AWIDTH.
- TIMEOUT, 16, cycles in WAIT_BURST before a partial drain is forced; must be >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_n_i  in  1  reset: asynchronous assert, active-low; deassertion is synchronised externally.
- fifo_q_i  in  DWIDTH  fifo show-ahead output word.
- fifo_empty_i  in  1  fifo empty flag.
- fifo_usedw_i  in  AWIDTH+1  fifo fill level.
- fifo_rdreq_o  out  1  fifo read acknowledge (pop).
- flush_i  in  1  single-cycle request to drain immediately, regardless of fill level.
- src_data_o  out  DWIDTH  stream data.
- src_valid_o  out  1  stream valid.
- src_ready_i  in  1  stream ready.
- src_startofpacket_o  out  1  first word of a packet.
- src_endofpacket_o  out  1  last word of a packet (word PKT_LEN).
- idle_o  out  1  high when state is IDLE and the skid buffer is empty.

Behaviour:
- Reset (arst_n_i low, takes effect immediately):
  - state = IDLE, skid buffer emptied, word and timeout counters = 0.
  - Outputs: src_valid_o=0, fifo_rdreq_o=0, src_startofpacket_o=0, src_endofpacket_o=0, src_data_o=0, idle_o=1.
  - Reset mid-packet discards buffered words; the next packet starts with SOP.
- FSM states: IDLE, WAIT_BURST, DRAIN.
  - IDLE -> DRAIN if !fifo_empty_i and (usedw >= BURST_THRESHOLD or flush_i).
  - IDLE -> WAIT_BURST if !fifo_empty_i otherwise.
  - WAIT_BURST: timeout counter increments every cycle.
    - -> DRAIN when usedw >= BURST_THRESHOLD, or flush_i, or counter == TIMEOUT-1.
    - Counter clears on exit.
  - DRAIN -> IDLE on the cycle fifo_rdreq_o pops the last word (usedw == 1 with rdreq), or when fifo_empty_i is sampled high.
- FIFO read:
  - fifo_rdreq_o = (state==DRAIN) and !fifo_empty_i and skid has room.
  - Room = occupancy < 2, or occupancy == 2 with an output pop in the same cycle.
  - rdreq is never asserted while fifo_empty_i is high. fifo_q_i is captured in the same cycle as rdreq (show-ahead).
- Latency: word on fifo_q_i with rdreq at cycle N appears on src_data_o with src_valid_o=1 at cycle N+1.
- Skid buffer:
  - 2-entry FIFO-ordered register pair, head driving src_*.
  - Pop when src_valid_o and src_ready_i.
  - Simultaneous push and pop keeps occupancy; push with occupancy 2 and no pop is impossible by the rdreq rule.
- Stream rules:
  - src_data_o and the SOP/EOP flags are held stable while src_valid_o and !src_ready_i.
  - src_valid_o never drops without a handshake.
- Framing:
  - Word counter (width clog2(PKT_LEN), min 1) counts accepted pushes.
  - SOP is tagged when count==0, EOP when count==PKT_LEN-1; the counter then wraps to 0.
  - PKT_LEN=1 gives SOP and EOP on every word.
  - Packets may span multiple bursts; a timeout does not close a packet.
- flush_i in DRAIN has no effect. flush_i with an empty FIFO is ignored.
- idle_o = (state==IDLE) and occupancy==0; combinational from registers.

Decomposition:
- Package fifo_stream_pkg:
  - state enum drain_state_t {IDLE, WAIT_BURST, DRAIN}.
  - Struct skid_entry_t {data, sop, eop}.
  - Width helper constants for the counters.
- One sub-module, stream_skid_buf: 2-entry valid/ready skid buffer parameterised on the entry type width. It provides push/room on the input and valid/ready on the output.

Test Plan:
- Threshold drain: write 4 words 0xA0..0xA3 with ready=1.
  - Response: WAIT_BURST is skipped; 4 rdreq pulses on consecutive cycles; src words 0xA0..0xA3 starting 1 cycle after the first rdreq; SOP on 0xA0, no EOP; return to IDLE, idle_o=1.
- Timeout: write 2 words, hold usedw=2.
  - Response: DRAIN is entered exactly 16 cycles after entering WAIT_BURST; both words are emitted; the word counter ends at 2.
- Backpressure: 8 words buffered, src_ready_i toggled 1,0,0,1 repeating.
  - Response: no word lost or duplicated; data stable while stalled; occupancy never >2; rdreq=0 while full with no pop; EOP on word 8 only.
- Packet spanning bursts: PKT_LEN=8, drain 5 then 3 words (timeout between).
  - Response: SOP on word 1, EOP on word 8; the next word carries SOP.
- Flush: 1 word in FIFO, pulse flush_i in WAIT_BURST.
  - Response: DRAIN the next cycle and the word is emitted. flush_i with the FIFO empty leaves state at IDLE.
- Async reset mid-drain: assert arst_n_i low between clock edges with occupancy 2.
  - Response: src_valid_o and fifo_rdreq_o drop immediately (no clock edge needed); after release, the first emitted word has SOP.
